mxint_exp_pipe: RTL and testbench

Pipelined, back-pressure-aware MXINT exponential for the attention softmax path. Takes one MXINT block per beat: BLOCK_SIZE signed mantissas plus one shared exponent. Computes e^x = 2^(x·log2e) per lane and returns a mantissa/exponent pair per lane. Adds three things: registered stages with valid/ready, saturation of the integer part n with an overflow flag, and an optional shared-exponent output stage that produces true MXINT output.

---
 rtl/mxint_exp_pkg.sv | 50 +++++
 rtl/mxint_exp_pow2_rom.sv | 22 ++
 rtl/mxint_exp_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_mxint_exp_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_exp_pkg.sv
// Shared constants, width helpers and stage metadata for the MXINT exponential pipeline.
package mxint_exp_pkg;

    // log2(e) ~= 92 / 2^7 * 2^1 = 1.4375
    localparam int LOG2E_MAN   = 92;
    localparam int LOG2E_EXP   = 1;
    localparam int LOG2E_MAN_W = 8;

    function automatic int prod_w(input int man_w);
        return man_w + LOG2E_MAN_W;
    endfunction

    function automatic int prod_frac(input int man_w);
        return (man_w - 1) + (LOG2E_MAN_W - 1);
    endfunction

    function automatic int cast_w(input int n_w, input int r_w);
        return n_w + r_w;
    endfunction

    // Right-shift distance from product to y when the adjusted exponent is zero.
    function automatic int shift_base(input int man_w, input int r_w);
        return prod_frac(man_w) - (r_w - 1);
    endfunction

    function automatic int shift_w(input int man_w, input int exp_w, input int r_w);
        return $clog2(shift_base(man_w, r_w) + (1 << exp_w) + 2) + 2;
    endfunction

    function automatic int lshift_max(input int man_w, input int exp_w, input int r_w);
        int v;
        v = (1 << (exp_w - 1)) + LOG2E_EXP - shift_base(man_w, r_w);
        return (v > 0) ? v : 0;
    endfunction

    // Wide enough that a left shift never drops bits and the saturation bounds fit.
    function automatic int y_w(input int man_w, input int exp_w, input int n_w, input int r_w);
        int a;
        int b;
        a = prod_w(man_w) + lshift_max(man_w, exp_w, r_w);
        b = cast_w(n_w, r_w);
        return ((a > b) ? a : b) + 1;
    endfunction

    typedef struct packed {
        logic valid;
        logic ovf;
    } beat_meta_t;

endpackage

// File: rtl/mxint_exp_pow2_rom.sv
// Combinational 2^r lookup: entry k = round-half-up(2^(k/2^R_FRAC_W) * 2^(MAN_W-2)).
module mxint_exp_pow2_rom #(
    parameter int R_FRAC_W = 6,
    parameter int MAN_W    = 10
) (
    input  logic [R_FRAC_W-1:0] i_r,
    output logic [MAN_W-1:0]    o_mant
);
    localparam int ENTRIES = 1 << R_FRAC_W;

    logic [MAN_W-1:0] w_table [ENTRIES];

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        localparam real EXPO = real'(gi) / real'(ENTRIES);
        localparam real VAL  = (2.0 ** EXPO) * real'(1 << (MAN_W - 2));
        localparam int  CODE = $rtoi($floor(VAL + 0.5));
        assign w_table[gi] = MAN_W'(CODE);
    end

    assign o_mant = w_table[i_r];

endmodule

// File: rtl/mxint_exp_pipe.sv
// Pipelined MXINT e^x with valid/ready stages and n saturation.
// Define MXINT_EXP_SHARED_EXP_EN to add a fourth stage that aligns all lanes to a shared exponent.
module mxint_exp_pipe
    import mxint_exp_pkg::*;
#(
    parameter int DATA_IN_MAN_WIDTH  = 8,
    parameter int DATA_IN_EXP_WIDTH  = 3,
    parameter int BLOCK_SIZE         = 16,
    parameter int DATA_OUT_MAN_WIDTH = 10,
    parameter int DATA_OUT_EXP_WIDTH = 4,
    parameter int DATA_R_WIDTH       = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_IN_MAN_WIDTH-1:0]  mdata_in_0 [BLOCK_SIZE],
    input  logic [DATA_IN_EXP_WIDTH-1:0]  edata_in_0,
    input  logic                          data_in_0_valid,
    output logic                          data_in_0_ready,
    output logic [DATA_OUT_MAN_WIDTH-1:0] mdata_out_0 [BLOCK_SIZE],
    output logic [DATA_OUT_EXP_WIDTH-1:0] edata_out_0 [BLOCK_SIZE],
    output logic                          overflow_0,
    output logic                          data_out_0_valid,
    input  logic                          data_out_0_ready
);
    localparam int MW  = DATA_IN_MAN_WIDTH;
    localparam int EW  = DATA_IN_EXP_WIDTH;
    localparam int EW1 = EW + 1;
    localparam int BS  = BLOCK_SIZE;
    localparam int OMW = DATA_OUT_MAN_WIDTH;
    localparam int NW  = DATA_OUT_EXP_WIDTH;
    localparam int RW  = DATA_R_WIDTH;
    localparam int FW  = RW - 1;
    localparam int PW  = prod_w(MW);
    localparam int SB  = shift_base(MW, RW);
    localparam int SW  = shift_w(MW, EW, RW);
    localparam int YW  = y_w(MW, EW, NW, RW);

    localparam logic signed [YW-1:0] Y_HI = YW'(longint'(1) << (NW - 1 + FW));
    localparam logic signed [NW-1:0] N_MAX = {1'b0, {(NW-1){1'b1}}};
    localparam logic signed [NW-1:0] N_MIN = {1'b1, {(NW-1){1'b0}}};

    logic                 r_v1;
    logic signed [PW-1:0] r_prod [BS];
    logic signed [EW:0]   r_e1;

    logic                 r_v2;
    logic signed [NW-1:0] r_n2 [BS];
    logic [FW-1:0]        r_r2 [BS];
    logic [BS-1:0]        r_sat2;

    beat_meta_t           r_m3;
    logic [OMW-1:0]       r_mant3 [BS];
    logic signed [NW-1:0] r_n3 [BS];

    logic                 w_s1_ready;
    logic                 w_s2_ready;
    logic                 w_s3_ready;
    logic signed [PW-1:0] w_prod [BS];
    logic signed [SW-1:0] w_amt;
    logic signed [NW-1:0] w_n [BS];
    logic [FW-1:0]        w_r [BS];
    logic [BS-1:0]        w_sat;
    logic [OMW-1:0]       w_mant [BS];

    assign w_s2_ready      = !r_v2 || w_s3_ready;
    assign w_s1_ready      = !r_v1 || w_s2_ready;
    assign data_in_0_ready = rst && w_s1_ready;

    // Negative amount means the exponent is large enough to need a left shift.
    assign w_amt = SW'(SB) - SW'(r_e1);

    for (genvar gi = 0; gi < BS; gi++) begin : g_lane
        logic signed [YW-1:0] w_x;
        logic signed [YW-1:0] w_y;
        logic                 w_hi;
        logic                 w_lo;

        assign w_prod[gi] = PW'($signed(mdata_in_0[gi])) * PW'(LOG2E_MAN);

        assign w_x  = YW'(r_prod[gi]);
        assign w_y  = (w_amt >= 0) ? (w_x >>> w_amt) : (w_x <<< (-w_amt));
        assign w_hi = (w_y >= Y_HI);
        assign w_lo = (w_y < -Y_HI);

        assign w_sat[gi] = w_hi || w_lo;
        assign w_n[gi]   = w_hi ? N_MAX : (w_lo ? N_MIN : w_y[FW +: NW]);
        assign w_r[gi]   = w_hi ? {FW{1'b1}} : (w_lo ? {FW{1'b0}} : w_y[FW-1:0]);

        mxint_exp_pow2_rom #(
            .R_FRAC_W (FW),
            .MAN_W    (OMW)
        ) u_rom (
            .i_r    (r_r2[gi]),
            .o_mant (w_mant[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1   <= 1'b0;
            r_e1   <= '0;
            r_v2   <= 1'b0;
            r_sat2 <= '0;
            r_m3   <= '0;
            for (int i = 0; i < BS; i++) begin
                r_prod[i]  <= '0;
                r_n2[i]    <= '0;
                r_r2[i]    <= '0;
                r_mant3[i] <= '0;
                r_n3[i]    <= '0;
            end
        end else begin
            if (w_s1_ready) begin
                r_v1 <= data_in_0_valid;
                if (data_in_0_valid) begin
                    r_e1 <= EW1'($signed(edata_in_0)) + EW1'(LOG2E_EXP);
                    for (int i = 0; i < BS; i++) begin
                        r_prod[i] <= w_prod[i];
                    end
                end
            end
            if (w_s2_ready) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_sat2 <= w_sat;
                    for (int i = 0; i < BS; i++) begin
                        r_n2[i] <= w_n[i];
                        r_r2[i] <= w_r[i];
                    end
                end
            end
            if (w_s3_ready) begin
                r_m3.valid <= r_v2;
                if (r_v2) begin
                    r_m3.ovf <= |r_sat2;
                    for (int i = 0; i < BS; i++) begin
                        r_mant3[i] <= w_mant[i];
                        r_n3[i]    <= r_n2[i];
                    end
                end
            end
        end
    end

`ifdef MXINT_EXP_SHARED_EXP_EN
    localparam int NW1 = NW + 1;

    beat_meta_t           r_m4;
    logic [OMW-1:0]       r_mant4 [BS];
    logic signed [NW-1:0] r_e4;
    logic signed [NW-1:0] w_emax;
    logic [OMW-1:0]       w_mant_sh [BS];
    logic                 w_s4_ready;

    assign w_s4_ready = !r_m4.valid || data_out_0_ready;
    assign w_s3_ready = !r_m3.valid || w_s4_ready;

    always_comb begin
        w_emax = r_n3[0];
        for (int i = 1; i < BS; i++) begin
            if (r_n3[i] > w_emax) begin
                w_emax = r_n3[i];
            end
        end
    end

    for (genvar gi = 0; gi < BS; gi++) begin : g_align
        logic [NW:0] w_dist;
        assign w_dist        = NW1'(w_emax) - NW1'(r_n3[gi]);
        assign w_mant_sh[gi] = (32'(w_dist) >= OMW) ? '0 : (r_mant3[gi] >> w_dist);
        assign mdata_out_0[gi] = r_mant4[gi];
        assign edata_out_0[gi] = r_e4;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m4 <= '0;
            r_e4 <= '0;
            for (int i = 0; i < BS; i++) begin
                r_mant4[i] <= '0;
            end
        end else if (w_s4_ready) begin
            r_m4.valid <= r_m3.valid;
            if (r_m3.valid) begin
                r_m4.ovf <= r_m3.ovf;
                r_e4     <= w_emax;
                for (int i = 0; i < BS; i++) begin
                    r_mant4[i] <= w_mant_sh[i];
                end
            end
        end
    end

    assign overflow_0       = r_m4.ovf;
    assign data_out_0_valid = r_m4.valid;
`else
    assign w_s3_ready = !r_m3.valid || data_out_0_ready;

    for (genvar gi = 0; gi < BS; gi++) begin : g_out
        assign mdata_out_0[gi] = r_mant3[gi];
        assign edata_out_0[gi] = r_n3[gi];
    end

    assign overflow_0       = r_m3.ovf;
    assign data_out_0_valid = r_m3.valid;
`endif

endmodule

// File: tb/tb_mxint_exp_pipe.sv
// Scoreboard bench for mxint_exp_pipe: directed beats, stall/back-pressure and mid-flight reset.
module tb_mxint_exp_pipe;
    localparam int MW  = 8;
    localparam int EW  = 3;
    localparam int BS  = 16;
    localparam int OMW = 10;
    localparam int NW  = 4;
    localparam int RW  = 7;
`ifdef MXINT_EXP_SHARED_EXP_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [MW-1:0]  mdata_in_0 [BS];
    logic [EW-1:0]  edata_in_0;
    logic           data_in_0_valid;
    logic           data_in_0_ready;
    logic [OMW-1:0] mdata_out_0 [BS];
    logic [NW-1:0]  edata_out_0 [BS];
    logic           overflow_0;
    logic           data_out_0_valid;
    logic           data_out_0_ready;

    always #5 clk = ~clk;

    mxint_exp_pipe #(
        .DATA_IN_MAN_WIDTH  (MW),
        .DATA_IN_EXP_WIDTH  (EW),
        .BLOCK_SIZE         (BS),
        .DATA_OUT_MAN_WIDTH (OMW),
        .DATA_OUT_EXP_WIDTH (NW),
        .DATA_R_WIDTH       (RW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mdata_in_0       (mdata_in_0),
        .edata_in_0       (edata_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .mdata_out_0      (mdata_out_0),
        .edata_out_0      (edata_out_0),
        .overflow_0       (overflow_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready)
    );

    typedef struct packed {
        logic [BS-1:0][OMW-1:0] mant;
        logic [BS-1:0][NW-1:0]  e;
        logic                   ovf;
        int                     acc;
    } exp_t;

    exp_t              sb_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    int                n_acc = 0;
    logic              acc_now = 1'b0;
    logic              smp_in_ready = 1'b0;
    logic              lat_chk = 1'b0;
    logic signed [7:0] cur_man [BS];
    int                cur_e = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic exp_t model_beat();
        exp_t x;
        int   n [BS];
        int   m [BS];
        int   emax;
        int   prod, amt, y, r, d;
        x    = '0;
        emax = -1000;
        for (int i = 0; i < BS; i++) begin
            prod = int'(cur_man[i]) * 92;
            amt  = 14 - 6 - (cur_e + 1);
            y    = (amt >= 0) ? (prod >>> amt) : (prod <<< (-amt));
            if (y >= 512) begin
                n[i] = 7;  r = 63; x.ovf = 1'b1;
            end else if (y < -512) begin
                n[i] = -8; r = 0;  x.ovf = 1'b1;
            end else begin
                n[i] = y >>> 6; r = y & 63;
            end
            m[i] = $rtoi($floor((2.0 ** (real'(r) / 64.0)) * 256.0 + 0.5));
            if (n[i] > emax) emax = n[i];
        end
        for (int i = 0; i < BS; i++) begin
`ifdef MXINT_EXP_SHARED_EXP_EN
            d         = emax - n[i];
            m[i]      = (d >= OMW) ? 0 : (m[i] >> d);
            x.e[i]    = NW'(emax);
`else
            d         = 0;
            x.e[i]    = NW'(n[i] + d);
`endif
            x.mant[i] = OMW'(m[i]);
        end
        return x;
    endfunction

    task automatic check_out();
        exp_t x;
        if (sb_q.size() == 0) begin
            chk("out_valid_with_empty_scoreboard", 32'(data_out_0_valid), 0);
        end else begin
            x = sb_q[0];
            for (int i = 0; i < BS; i++) begin
                chk($sformatf("mant[%0d]", i), 32'(mdata_out_0[i]), 32'(x.mant[i]));
                chk($sformatf("edata[%0d]", i), 32'(edata_out_0[i]), 32'(x.e[i]));
            end
            chk("overflow", 32'(overflow_0), 32'(x.ovf));
            if (lat_chk && data_out_0_ready) chk("latency", cyc - x.acc, LAT);
            if (data_out_0_ready) void'(sb_q.pop_front());
        end
    endtask

    task automatic cycle();
        exp_t x;
        @(negedge clk);
        smp_in_ready = data_in_0_ready;
        acc_now      = data_in_0_valid && data_in_0_ready;
        if (data_out_0_valid) check_out();
        if (acc_now) begin
            x     = model_beat();
            x.acc = cyc;
            sb_q.push_back(x);
            n_acc++;
            $display("accept beat %0d at cycle %0d e=%0d lane0=%0d", n_acc, cyc, cur_e, cur_man[0]);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive();
        for (int i = 0; i < BS; i++) mdata_in_0[i] = cur_man[i];
        edata_in_0 = EW'(cur_e);
    endtask

    task automatic set_all(input int man, input int e);
        for (int i = 0; i < BS; i++) cur_man[i] = 8'(man);
        cur_e = e;
    endtask

    task automatic set_rand();
        for (int i = 0; i < BS; i++) cur_man[i] = 8'($urandom_range(0, 255));
        cur_e = int'($urandom_range(0, 7)) - 4;
    endtask

    task automatic send(input int budget);
        int k;
        k = 0;
        drive();
        data_in_0_valid = 1'b1;
        do begin
            cycle();
            k++;
        end while (!acc_now && k < budget);
        chk("accept_within_budget", 32'(acc_now), 1);
        data_in_0_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_out_valid"}, 32'(data_out_0_valid), 0);
        chk({tag, "_in_ready"}, 32'(data_in_0_ready), 0);
        chk({tag, "_overflow"}, 32'(overflow_0), 0);
        for (int i = 0; i < BS; i++) begin
            chk($sformatf("%s_mant[%0d]", tag, i), 32'(mdata_out_0[i]), 0);
            chk($sformatf("%s_edata[%0d]", tag, i), 32'(edata_out_0[i]), 0);
        end
    endtask

    // 8 back-to-back beats, output stalled for steps 2..7; optional reset at step 5.
    task automatic stall_run(input logic with_reset);
        int k;
        int start;
        k     = 0;
        start = n_acc;
        set_rand();
        drive();
        while ((n_acc - start) < 8 && k < 40) begin
            data_out_0_ready = (k < 2 || k > 7);
            data_in_0_valid  = 1'b1;
            if (with_reset && k == 5) begin
                rst = 1'b0;
                cycle();
                chk_cleared("midrst");
                sb_q.delete();
                rst             = 1'b1;
                data_in_0_valid = 1'b0;
                data_out_0_ready = 1'b1;
                break;
            end
            cycle();
            if (k == 2) chk("in_ready_before_full", 32'(smp_in_ready), 1);
            if (k == 3) chk("held_beats_when_full", n_acc - start, 3);
            if (k == 3 || k == 7) chk("in_ready_while_stalled", 32'(smp_in_ready), 0);
            if (acc_now) begin
                set_rand();
                drive();
            end
            k++;
        end
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
    endtask

    initial begin
        rst              = 1'b0;
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
        set_all(0, 0);
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        rst = 1'b1;

        lat_chk = 1'b1;
        set_all(0, 0);
        send(4);
        drain(20);

        set_all(0, 1);
        cur_man[0] = 8'sd64;
        cur_man[1] = -8'sd64;
        send(4);
        drain(20);

        set_all(0, 3);
        cur_man[0] = 8'sd127;
        cur_man[1] = -8'sd128;
        send(4);
        drain(20);

        set_all(127, 3);
        send(4);
        drain(20);
        lat_chk = 1'b0;

        for (int b = 0; b < 4; b++) begin
            set_rand();
            send(4);
        end
        drain(30);

        stall_run(1'b0);
        drain(40);

        stall_run(1'b1);
        chk("scoreboard_flushed_by_reset", sb_q.size(), 0);
        lat_chk = 1'b1;
        set_all(0, 1);
        cur_man[0] = 8'sd64;
        cur_man[1] = -8'sd64;
        send(1);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
